// File: rtl/truth_sweep.sv
// Truth-table sweep: steps abc through 0..7, samples y after SETTLE cycles each,
// and compares the captured table with EXPECTED. Optional err_count under TRUTH_SWEEP_ERRCNT_EN.
module truth_sweep #(
  parameter int         SETTLE   = 1,
  parameter logic [7:0] EXPECTED = 8'h87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic [2:0] abc,
  output logic       busy,
  output logic       done,
  output logic [7:0] ttable,
`ifdef TRUTH_SWEEP_ERRCNT_EN
  output logic [3:0] err_count,
`endif
  output logic       match
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] abc_q, abc_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] ttable_q, ttable_d;
  logic       match_q, match_d;
  logic [7:0] tt_cap;
`ifdef TRUTH_SWEEP_ERRCNT_EN
  logic [3:0] err_q, err_d;
`endif

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) sum = sum + {3'b000, v[i]};
    return sum;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      abc_q    <= 3'd0;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ttable_q <= 8'h00;
      match_q  <= 1'b0;
`ifdef TRUTH_SWEEP_ERRCNT_EN
      err_q    <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      abc_q    <= abc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ttable_q <= ttable_d;
      match_q  <= match_d;
`ifdef TRUTH_SWEEP_ERRCNT_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    abc_d    = abc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ttable_d = ttable_q;
    match_d  = match_q;
`ifdef TRUTH_SWEEP_ERRCNT_EN
    err_d    = err_q;
`endif
    // Table including the bit sampled this cycle, so match sees the final bit.
    tt_cap         = ttable_q;
    tt_cap[abc_q]  = y;

    unique case (state_q)
      IDLE: begin
        abc_d = 3'd0;
        if (start) begin
          ttable_d = 8'h00;
          match_d  = 1'b0;
          cnt_d    = 4'd0;
          busy_d   = 1'b1;
          state_d  = SWEEP;
`ifdef TRUTH_SWEEP_ERRCNT_EN
          err_d    = 4'd0;
`endif
        end
      end
      SWEEP: begin
        if (cnt_q == CNT_LAST) begin
          ttable_d = tt_cap;
          if (abc_q != 3'd7) begin
            abc_d = abc_q + 3'd1;
            cnt_d = 4'd0;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = (tt_cap == EXPECTED);
`ifdef TRUTH_SWEEP_ERRCNT_EN
            err_d   = popcount8(tt_cap ^ EXPECTED);
`endif
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
        abc_d   = 3'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign abc    = abc_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign ttable = ttable_q;
  assign match  = match_q;
`ifdef TRUTH_SWEEP_ERRCNT_EN
  assign err_count = err_q;
`endif

endmodule

// File: doc/truth_sweep.md
# truth_sweep

Sequential stimulus-and-capture stage wrapped around the three-input expression block `exp_mux`. On a start pulse it drives the expression's `a`, `b` and `c` inputs through all eight combinations and samples `y` for each one. It assembles the results into an 8-bit truth table and compares that table against an expected constant. It replaces hand-written stimulus sequences with a self-checking hardware sweep.

## Interface

Parameters:
- `SETTLE`, default 1: cycles each combination is held before `y` is sampled; legal range 1..15.
- `EXPECTED`, default 8'h87: expected truth table; bit i = y for {a,b,c} = i.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. Sampled in IDLE only; begins a sweep.
- `y`: input, 1 bit. Output of the expression stage under test.
- `abc`: output, 3 bits. Drives the stage inputs: a = `abc[2]`, b = `abc[1]`, c = `abc[0]`.
- `busy`: output, 1 bit. High while a sweep is in progress.
- `done`: output, 1 bit. One-cycle pulse when the table is complete.
- `ttable`: output, 8 bits. Captured truth table.
- `match`: output, 1 bit. High when `ttable` equals `EXPECTED`; valid from `done` onward.

## Operation

States: IDLE, SWEEP, DONE.
- IDLE:
  - `abc` = 0.
  - If `start` = 1 at an edge: `ttable` <= 0, `match` <= 0, `cnt` <= 0, `busy` <= 1, go to SWEEP.
- SWEEP:
  - `cnt` (4-bit) counts 0..SETTLE-1 with `abc` held.
  - At the edge where `cnt` = SETTLE-1: `ttable[abc]` <= `y`.
  - If `abc` < 7 at that edge: `abc` <= `abc` + 1 and `cnt` <= 0.
  - If `abc` = 7 at that edge: go to DONE, `busy` <= 0, `done` <= 1, and `match` <= (table including the bit just captured == `EXPECTED`).
- DONE:
  - Lasts exactly one cycle, then IDLE with `done` <= 0 and `abc` <= 0.
- `start` is ignored in SWEEP and DONE. It is level-sampled only in IDLE, so a held `start` re-triggers on the first IDLE cycle.
- `ttable` and `match` hold their values from DONE until the next accepted `start`.
- No wrap-around: `abc` never increments past 7.

## Timing

- Reset (asynchronous, any state):
  - State = IDLE.
  - `abc` = 0, `busy` = 0, `done` = 0, `ttable` = 8'h00, `match` = 0, `cnt` = 0.
  - Any sweep in progress is abandoned with no partial result.
- Let E0 be the edge that accepts `start`:
  - `busy` rises after E0.
  - Combination i is driven from E0 + i·SETTLE to E0 + (i+1)·SETTLE.
  - `y` for combination i is sampled at edge E0 + (i+1)·SETTLE.
- `done` is high for the single cycle following edge E0 + 8·SETTLE. `busy` falls at that same edge.
- Latency from start acceptance to `done` is 8·SETTLE cycles.
- The stage under test must be combinational, or must settle within SETTLE cycles.

## Configuration

- `TRUTH_SWEEP_ERRCNT_EN` defined:
  - Adds output `err_count` (4 bits) = popcount(table ^ `EXPECTED`).
  - It is registered at the same edge as `done`, cleared by `start` acceptance and by reset, and held otherwise.
- `TRUTH_SWEEP_ERRCNT_EN` undefined: the `err_count` port and its logic are absent. All other behaviour is identical.

## Test plan

- Correct stage, SETTLE = 1:
  - Pulse `start`; `abc` steps 0..7, one cycle each.
  - `done` is high in the 9th cycle after acceptance, with `ttable` = 8'h87 and `match` = 1.
  - If enabled, `err_count` = 0.
- `y` tied to 0:
  - `ttable` = 8'h00, `match` = 0.
  - If enabled, `err_count` = 4.
- SETTLE = 3, correct stage:
  - Each `abc` value is held for 3 cycles; `done` fires 24 cycles after acceptance.
  - `ttable` = 8'h87.
- `start` pulsed again while `abc` = 3:
  - Ignored; the sweep completes unchanged and `done` fires at the original cycle.
- `rst_n` asserted while `abc` = 4:
  - All outputs go to 0 immediately.
  - After release, a new `start` runs a full sweep from `abc` = 0 and yields 8'h87.
- `start` held high continuously:
  - Back-to-back sweeps, separated by one DONE cycle and one IDLE cycle.
  - `ttable` is cleared to 0 at each new acceptance.
